// File: rtl/uart_tx_stage.sv
// uart_tx_stage: buffers upstream bytes in a small FIFO and serialises them as 8N1 UART frames on tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_stage #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH = 4
) (
   input  logic clka,
   input  logic rst,
   input  logic in_valid,
   input  logic [7:0] in_data,
   output logic in_ready,
   output logic tx,
   output logic busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   logic r_par;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
   state_t r_state;
   logic [7:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0] r_count;
   logic [BW-1:0] r_baud;
   logic [2:0] r_bit;
   logic [7:0] r_shift;
   logic r_tx;
   logic w_push, w_pop, w_last;
   logic [7:0] w_head;
   assign in_ready = (r_count != FULL);
   assign w_push = in_valid && in_ready;
   assign w_last = (r_baud == LAST);
   assign w_pop = (r_count != '0) && (r_state == IDLE || (r_state == STOP && w_last));
   assign w_head = r_mem[r_rp];
   assign tx = r_tx;
   assign busy = (r_state != IDLE);
   assign fifo_count = r_count;
   always_ff @(posedge clka) begin
      if (w_push) r_mem[r_wp] <= in_data;
   end
   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_wp <= '0;
         r_rp <= '0;
         r_count <= '0;
         r_baud <= '0;
         r_bit <= '0;
         r_shift <= '0;
         r_tx <= 1'b1;
`ifdef UART_TX_PARITY_EN
         r_par <= 1'b0;
`endif
      end else begin
         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop) r_rp <= r_rp + AW'(1);
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
         r_baud <= (r_state == IDLE || w_last) ? '0 : r_baud + BW'(1);
         // A pop always starts a new frame, from IDLE or straight out of STOP.
         if (w_pop) begin
            r_shift <= w_head;
            r_tx <= 1'b0;
            r_state <= START;
`ifdef UART_TX_PARITY_EN
            r_par <= ^w_head;
`endif
         end else if (w_last) begin
            case (r_state)
               START: begin
                  r_tx <= r_shift[0];
                  r_bit <= '0;
                  r_state <= DATA;
               end
               DATA: begin
                  if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     r_tx <= r_par;
                     r_state <= PARITY;
`else
                     r_tx <= 1'b1;
                     r_state <= STOP;
`endif
                  end else begin
                     r_shift <= {1'b0, r_shift[7:1]};
                     r_tx <= r_shift[1];
                     r_bit <= r_bit + 3'd1;
                  end
               end
`ifdef UART_TX_PARITY_EN
               PARITY: begin
                  r_tx <= 1'b1;
                  r_state <= STOP;
               end
`endif
               STOP: r_state <= IDLE;
               default: r_state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_stage.sv
// tb_uart_tx_stage: randomized and directed stimulus against a per-cycle tx waveform model.
// The model keeps a byte queue and a queue of upcoming tx levels, one entry per clka cycle.
module tb_uart_tx_stage;
   localparam int C = 4;
   localparam int D = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME = 11 * C;
`else
   localparam int FRAME = 10 * C;
`endif
   logic clka = 1'b0;
   logic rst = 1'b0;
   logic in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic in_ready, tx, busy;
   logic [2:0] fifo_count;
   int total = 0;
   int bad = 0;
   int busy_cycles = 0;
   bit acc;
   byte unsigned q[$];
   bit wave[$];
   uart_tx_stage #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
      .clka(clka), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
   );
   always #5 clka = ~clka;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic add_frame(input byte unsigned b);
      for (int k = 0; k < C; k++) wave.push_back(1'b0);
      for (int i = 0; i < 8; i++)
         for (int k = 0; k < C; k++) wave.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
      for (int k = 0; k < C; k++) wave.push_back(^b);
`endif
      for (int k = 0; k < C; k++) wave.push_back(1'b1);
   endtask
   task automatic step();
      bit full;
      @(posedge clka);
      full = (q.size() == D);
      if (wave.size() != 0) void'(wave.pop_front());
      if (wave.size() == 0 && q.size() != 0) add_frame(q.pop_front());
      acc = in_valid && !full;
      if (acc) q.push_back(in_data);
      #1;
      if (busy === 1'b1) busy_cycles++;
      chk("tx", tx, (wave.size() != 0) ? wave[0] : 1'b1);
      chk("busy", busy, wave.size() != 0);
      chk("in_ready", in_ready, q.size() != D);
      chk("fifo_count", fifo_count, q.size());
   endtask
   task automatic send(input byte unsigned s[$]);
      int idx = 0;
      int guard = 0;
      in_valid = 1'b1;
      in_data = s[0];
      while (idx < s.size() && guard < 2000) begin
         step();
         guard++;
         if (acc) idx++;
         if (idx < s.size()) in_data = s[idx];
         else in_valid = 1'b0;
      end
      in_valid = 1'b0;
      if (idx < s.size()) chk("send_timeout", idx, s.size());
   endtask
   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask
   initial begin
      #2 rst = 1'b1;
      #1;
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ready", in_ready, 1'b1);
      chk("rst_count", fifo_count, 0);
      @(negedge clka);
      @(negedge clka);
      rst = 1'b0;
      run(100);
      send('{8'hA5});
      run(FRAME + 5);
      busy_cycles = 0;
      send('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
      run(5 * FRAME + 10);
      chk("burst_busy_cycles", busy_cycles, 5 * FRAME);
      send('{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15});
      run(6 * FRAME + 10);
      send('{8'h07});
      send('{8'h03});
      run(2 * FRAME + 10);
      for (int i = 0; i < 500; i++) begin
         in_valid = ($urandom_range(0, 19) == 0);
         in_data = 8'($urandom);
         step();
      end
      for (int i = 0; i < 400; i++) begin
         in_valid = $urandom_range(0, 1);
         in_data = 8'($urandom);
         step();
      end
      in_valid = 1'b0;
      run(D * FRAME + 2 * FRAME);
      send('{8'hFF, 8'hAA, 8'hBB});
      run(16);
      #2 rst = 1'b1;
      #1;
      chk("midrst_tx", tx, 1'b1);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_count", fifo_count, 0);
      chk("midrst_ready", in_ready, 1'b1);
      q.delete();
      wave.delete();
      @(negedge clka);
      rst = 1'b0;
      busy_cycles = 0;
      run(60);
      chk("post_rst_busy_cycles", busy_cycles, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
